alu_exec: RTL

// Multi-cycle MIPS ALU. Consumes the ALU control code and the pre-muxed/extended operands produced by the ALU control

---
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle between ALU control and the execute ALU.
// The master drives the operation request; the slave returns result, flags and HI/LO.
interface alu_exec_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       ALUCr;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic             of_det;
   logic             sgn;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div0;

   modport master (
      output start, ALUCr, reg_a, reg_b, of_det, sgn,
      input  result, zero, overflow, hi, lo, busy, done, div0
   );

   modport slave (
      input  start, ALUCr, reg_a, reg_b, of_det, sgn,
      output result, zero, overflow, hi, lo, busy, done, div0
   );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle MIPS execute ALU: single-cycle logic/arith/shift ops plus iterative MULT/DIV into HI/LO.
// Define ALU_DIV0_TRAP_EN to short-circuit DIV by zero with a div0 flag instead of iterating.
module alu_exec #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_exec_if.slave io
);
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;
   localparam logic [3:0] OP_SRL  = 4'b1101;
   localparam logic [3:0] OP_SLL  = 4'b1110;
   localparam logic [3:0] OP_MULT = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b1010;
   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;
   state_t state_reg, state_next;

   logic [CW-1:0]    cnt_reg;
   logic [WIDTH:0]   acc_reg, acc_next;
   logic [WIDTH-1:0] low_reg, low_next, opnd_reg;
   logic             sign_a_reg, sign_b_reg, is_div_reg;
   logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
   logic             zero_reg, overflow_reg, done_reg;

   logic             accept, is_long, div_trap, busy;
   logic [WIDTH-1:0] mag_a, mag_b, alu_res, sum;
   logic             alu_ovf;
   logic [WIDTH:0]   mult_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   assign accept  = io.start && (state_reg == S_IDLE);
   assign is_long = (io.ALUCr == OP_MULT) || (io.ALUCr == OP_DIV);
`ifdef ALU_DIV0_TRAP_EN
   logic div0_reg;
   assign div_trap = (io.ALUCr == OP_DIV) && (io.reg_b == '0);
   assign io.div0  = div0_reg;
`else
   assign div_trap = 1'b0;
   assign io.div0  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (accept && is_long && !div_trap) state_next = S_ITER;
         S_ITER: if (cnt_reg == CW'(ITER - 1))       state_next = S_FIN;
         S_FIN:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_reg != S_IDLE);
   end

   // Single-cycle datapath
   always_comb begin
      sum     = io.reg_a + io.reg_b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (io.ALUCr)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = io.of_det && (io.reg_a[WIDTH-1] == io.reg_b[WIDTH-1])
                      && (sum[WIDTH-1] != io.reg_a[WIDTH-1]);
         end
         OP_AND: alu_res = io.reg_a & io.reg_b;
         OP_OR:  alu_res = io.reg_a | io.reg_b;
         OP_XOR: alu_res = io.reg_a ^ io.reg_b;
         OP_NOR: alu_res = ~(io.reg_a | io.reg_b);
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, io.sgn ? ($signed(io.reg_a) < $signed(io.reg_b))
                                                      : (io.reg_a < io.reg_b)};
         OP_SRA: alu_res = WIDTH'($signed(io.reg_a) >>> io.reg_b[SW-1:0]);
         OP_SRL: alu_res = io.reg_a >> io.reg_b[SW-1:0];
         OP_SLL: alu_res = io.reg_a << io.reg_b[SW-1:0];
         default: alu_res = '0;
      endcase
   end

   assign mag_a = (io.sgn && io.reg_a[WIDTH-1]) ? -io.reg_a : io.reg_a;
   assign mag_b = (io.sgn && io.reg_b[WIDTH-1]) ? -io.reg_b : io.reg_b;

   // One shift-add or restoring-divide step; acc holds the upper half / partial remainder
   always_comb begin
      acc_next  = acc_reg;
      low_next  = low_reg;
      mult_sum  = '0;
      div_shift = '0;
      div_diff  = '0;
      if (is_div_reg) begin
         div_shift = {acc_reg[WIDTH-1:0], low_reg[WIDTH-1]};
         div_diff  = div_shift - {1'b0, opnd_reg};
         if (!div_diff[WIDTH]) begin
            acc_next = div_diff;
            low_next = {low_reg[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = div_shift;
            low_next = {low_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         mult_sum = acc_reg + (low_reg[0] ? {1'b0, opnd_reg} : '0);
         acc_next = {1'b0, mult_sum[WIDTH:1]};
         low_next = {mult_sum[0], low_reg[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_fix = {acc_reg[WIDTH-1:0], low_reg};
      if (sign_a_reg ^ sign_b_reg) prod_fix = -prod_fix;
      if (is_div_reg) begin
         fix_lo = (sign_a_reg ^ sign_b_reg) ? -low_reg : low_reg;
         fix_hi = sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      end else begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         acc_reg      <= '0;
         low_reg      <= '0;
         opnd_reg     <= '0;
         sign_a_reg   <= 1'b0;
         sign_b_reg   <= 1'b0;
         is_div_reg   <= 1'b0;
         result_reg   <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         zero_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
`ifdef ALU_DIV0_TRAP_EN
         div0_reg     <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         if (accept) begin
`ifdef ALU_DIV0_TRAP_EN
            div0_reg <= div_trap;
`endif
            if (div_trap) begin
               result_reg   <= '0;
               zero_reg     <= 1'b1;
               overflow_reg <= 1'b0;
               done_reg     <= 1'b1;
            end else if (is_long) begin
               is_div_reg <= (io.ALUCr == OP_DIV);
               sign_a_reg <= io.sgn && io.reg_a[WIDTH-1];
               sign_b_reg <= io.sgn && io.reg_b[WIDTH-1];
               acc_reg    <= '0;
               cnt_reg    <= '0;
               // Divide shifts the dividend out of low; multiply shifts the multiplier out
               low_reg    <= (io.ALUCr == OP_DIV) ? mag_a : mag_b;
               opnd_reg   <= (io.ALUCr == OP_DIV) ? mag_b : mag_a;
            end else begin
               result_reg   <= alu_res;
               zero_reg     <= (alu_res == '0);
               overflow_reg <= alu_ovf;
               done_reg     <= 1'b1;
            end
         end
         if (state_reg == S_ITER) begin
            cnt_reg <= cnt_reg + 1'b1;
            acc_reg <= acc_next;
            low_reg <= low_next;
         end
         if (state_reg == S_FIN) begin
            hi_reg       <= fix_hi;
            lo_reg       <= fix_lo;
            result_reg   <= fix_lo;
            zero_reg     <= (fix_lo == '0);
            overflow_reg <= 1'b0;
            done_reg     <= 1'b1;
         end
      end
   end

   assign io.result   = result_reg;
   assign io.zero     = zero_reg;
   assign io.overflow = overflow_reg;
   assign io.hi       = hi_reg;
   assign io.lo       = lo_reg;
   assign io.busy     = busy;
   assign io.done     = done_reg;
endmodule
